// File: rtl/mvm_mac_sequencer.sv
// ---------------------------------------------------------------------------
// mvm_mac_sequencer
//
// Purpose: runs one bias-added matrix-vector job, y = M*x + b, on a single
// shared 8x8->16 MAC. For each row it clears the MAC and issues the K
// matrix/vector element pairs. It then waits for K MAC results, adds the row
// bias and writes the row result to the result buffer. A one-cycle done
// pulse follows the last row.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               job request, sampled only while idle
//   busy, done          busy in every state but IDLE; one-cycle done pulse
//   addr_m/x/b          operand memory read addresses
//   m/x/b_rd_data       operand read data, 1-cycle registered-read latency
//   mac_clear           MAC accumulator clear strobe
//   mac_a, mac_b        MAC operands (direct copies of m/x read data)
//   mac_valid_in        MAC operand strobe
//   mac_f               MAC running accumulation (signed)
//   mac_valid_out       one pulse per accepted operand pair, L>=1 cycles late
//   res_wr_en           result buffer write strobe
//   res_addr, res_data  result row index and signed 16-bit value
//
// All control outputs are registered and decoded from the next state, so
// each output reflects the state the FSM is currently in.
// ---------------------------------------------------------------------------
module mvm_mac_sequencer #(
    parameter int K    = 4,
    parameter int MLOG = 5,
    parameter int XLOG = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [MLOG-1:0] addr_m,
    output logic [XLOG-1:0] addr_x,
    output logic [XLOG-1:0] addr_b,
    input  logic [7:0]      m_rd_data,
    input  logic [7:0]      x_rd_data,
    input  logic [7:0]      b_rd_data,
    output logic            mac_clear,
    output logic [7:0]      mac_a,
    output logic [7:0]      mac_b,
    output logic            mac_valid_in,
    input  logic [15:0]     mac_f,
    input  logic            mac_valid_out,
    output logic            res_wr_en,
    output logic [XLOG-1:0] res_addr,
    output logic [15:0]     res_data
);

    // The valid_out counter must be able to hold K itself.
    localparam int VW = $clog2(K + 1);

    typedef enum logic [2:0] {IDLE, CLR, ISSUE, DRAIN, WB, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLOG-1:0] row_q, row_d;
    logic [XLOG-1:0] col_q, col_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic            issued_q;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mac_clear_q, mac_clear_d;
    logic            res_wr_en_q, res_wr_en_d;
    logic [MLOG-1:0] addr_m_q, addr_m_d;
    logic [XLOG-1:0] addr_x_q, addr_x_d;
    logic [XLOG-1:0] addr_b_q, addr_b_d;
    logic [XLOG-1:0] res_addr_q, res_addr_d;
    logic [15:0]     res_data_q, res_data_d;

    // NOTE: every signal written here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        vcnt_d     = vcnt_q;
        res_data_d = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                col_d   = '0;
                vcnt_d  = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                // With L>=1, early results of this row can already return here.
                if (mac_valid_out) vcnt_d = vcnt_q + VW'(1);
                if (col_q == XLOG'(K - 1)) state_d = DRAIN;
                else                       col_d   = col_q + XLOG'(1);
            end
            DRAIN: begin
                if (mac_valid_out) begin
                    vcnt_d = vcnt_q + VW'(1);
                    if (vcnt_q == VW'(K - 1)) begin
                        // Row result: final accumulation plus sign-extended
                        // bias, wrapping in 16 bits. The bias read data has
                        // been stable since the row's first ISSUE cycle.
                        res_data_d = mac_f + {{8{b_rd_data[7]}}, b_rd_data};
                        state_d    = WB;
                    end
                end
            end
            WB: begin
                row_d   = row_q + XLOG'(1);
                state_d = (row_q == XLOG'(K - 1)) ? DONE : CLR;
            end
            DONE: begin
                row_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs decoded from the state being entered.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        mac_clear_d = (state_d == CLR);
        res_wr_en_d = (state_d == WB);

        // Addresses hold their last value outside the phases that set them.
        addr_m_d   = addr_m_q;
        addr_x_d   = addr_x_q;
        addr_b_d   = addr_b_q;
        res_addr_d = res_addr_q;
        if (state_d == ISSUE) begin
            addr_m_d = MLOG'(row_d) * MLOG'(K) + MLOG'(col_d);
            addr_x_d = col_d;
        end
        if (state_d == CLR) addr_b_d   = row_d;
        if (state_d == WB)  res_addr_d = row_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            vcnt_q      <= '0;
            issued_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_clear_q <= 1'b0;
            res_wr_en_q <= 1'b0;
            addr_m_q    <= '0;
            addr_x_q    <= '0;
            addr_b_q    <= '0;
            res_addr_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            vcnt_q      <= vcnt_d;
            // An element was addressed this cycle, so its read data (and
            // therefore the MAC strobe) is valid next cycle.
            issued_q    <= (state_q == ISSUE);
            busy_q      <= busy_d;
            done_q      <= done_d;
            mac_clear_q <= mac_clear_d;
            res_wr_en_q <= res_wr_en_d;
            addr_m_q    <= addr_m_d;
            addr_x_q    <= addr_x_d;
            addr_b_q    <= addr_b_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mac_clear    = mac_clear_q;
    assign mac_valid_in = issued_q;
    assign res_wr_en    = res_wr_en_q;
    assign addr_m       = addr_m_q;
    assign addr_x       = addr_x_q;
    assign addr_b       = addr_b_q;
    assign res_addr     = res_addr_q;
    assign res_data     = res_data_q;
    assign mac_a        = m_rd_data;
    assign mac_b        = x_rd_data;

endmodule

// File: tb/tb_mvm_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mvm_mac_sequencer
//
// Testbench for mvm_mac_sequencer (K=4). It models the three operand
// memories with 1-cycle registered reads, plus a MAC with a selectable
// result latency (1..4) and optional spurious valid_out pulses. Jobs are run
// from directed operand sets with hand-computed results, and each write,
// done pulse and busy window is checked against the cycle it should occur
// in, counted from the cycle in which start is sampled.
// ---------------------------------------------------------------------------
module tb_mvm_mac_sequencer;

    localparam int K = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [4:0]  addr_m;
    logic [2:0]  addr_x, addr_b;
    logic [7:0]  m_rd_data, x_rd_data, b_rd_data;
    logic        mac_clear;
    logic [7:0]  mac_a, mac_b;
    logic        mac_valid_in;
    logic [15:0] mac_f;
    logic        mac_valid_out;
    logic        res_wr_en;
    logic [2:0]  res_addr;
    logic [15:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    int   mac_lat = 1;
    logic spur    = 1'b0;

    logic [7:0]  m_mem [32];
    logic [7:0]  x_mem [8];
    logic [7:0]  b_mem [8];
    logic [15:0] exp_res [4];

    mvm_mac_sequencer #(.K(4), .MLOG(5), .XLOG(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .addr_m        (addr_m),
        .addr_x        (addr_x),
        .addr_b        (addr_b),
        .m_rd_data     (m_rd_data),
        .x_rd_data     (x_rd_data),
        .b_rd_data     (b_rd_data),
        .mac_clear     (mac_clear),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_valid_in  (mac_valid_in),
        .mac_f         (mac_f),
        .mac_valid_out (mac_valid_out),
        .res_wr_en     (res_wr_en),
        .res_addr      (res_addr),
        .res_data      (res_data)
    );

    always #5 clk = ~clk;

    // Operand memories: registered read, one cycle of latency.
    always @(posedge clk) begin
        m_rd_data <= m_mem[addr_m];
        x_rd_data <= x_mem[addr_x];
        b_rd_data <= b_mem[addr_b];
    end

    // MAC: the accumulator updates on the strobe edge; the result and its
    // valid pulse then travel down a delay line and are tapped at mac_lat.
    logic [15:0] acc, acc_next, prod;
    logic [15:0] f_pipe [1:4];
    logic        v_pipe [1:4];

    assign prod     = 16'($signed(mac_a)) * 16'($signed(mac_b));
    assign acc_next = mac_clear ? 16'd0 : (mac_valid_in ? acc + prod : acc);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            for (int i = 1; i <= 4; i++) begin
                f_pipe[i] <= '0;
                v_pipe[i] <= 1'b0;
            end
        end else begin
            acc       <= acc_next;
            f_pipe[1] <= acc_next;
            v_pipe[1] <= mac_valid_in;
            for (int i = 2; i <= 4; i++) begin
                f_pipe[i] <= f_pipe[i-1];
                v_pipe[i] <= v_pipe[i-1];
            end
        end
    end

    assign mac_f         = f_pipe[mac_lat];
    assign mac_valid_out = v_pipe[mac_lat] | spur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy, done, mac_clear, mac_valid_in, res_wr_en}), 32'd0);
        check({tag, "_addr"}, 32'({addr_m, addr_x, addr_b, res_addr}), 32'd0);
        check({tag, "_data"}, 32'(res_data), 32'd0);
    endtask

    // M = identity, x = [1,2,3,4], b = [10,20,30,40] -> y = [11,22,33,44].
    task automatic load_identity();
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) m_mem[r*K+c] = (r == c) ? 8'd1 : 8'd0;
            x_mem[r] = 8'(r + 1);
            b_mem[r] = 8'(10 * (r + 1));
        end
        exp_res[0] = 16'd11;
        exp_res[1] = 16'd22;
        exp_res[2] = 16'd33;
        exp_res[3] = 16'd44;
    endtask

    // Caller must be at a falling edge with the DUT idle. Start is raised in
    // cycle 0; relative cycle n is the n-th falling edge after that.
    // rt is the expected row time; done is expected at cycle K*rt+1.
    task automatic run_job(input string tag, input int rt, input bit hold, input bit spur_wb);
        int exp_done  = K * rt + 1;
        int n_wr      = 0;
        int n_done    = 0;
        int done_cyc  = -1;
        int busy_err  = 0;
        int n_clr     = 0;
        int n_vin     = 0;
        int first_clr = -1;
        start = 1'b1;
        for (int rel = 1; rel <= exp_done + 1; rel++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy !== (rel <= exp_done)) busy_err++;
            if (mac_clear) begin
                n_clr++;
                if (first_clr < 0) first_clr = rel;
            end
            if (mac_valid_in) n_vin++;
            if (done) begin
                n_done++;
                done_cyc = rel;
            end
            if (res_wr_en) begin
                if (n_wr < K) begin
                    check({tag, "_wr_data"}, 32'(res_data), 32'(exp_res[n_wr]));
                    check({tag, "_wr_addr"}, 32'(res_addr), n_wr);
                    check({tag, "_wr_cycle"}, rel, (n_wr + 1) * rt);
                end
                n_wr++;
            end
            spur = spur_wb & res_wr_en;
        end
        spur = 1'b0;
        check({tag, "_n_writes"}, n_wr, K);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_busy_window_errs"}, busy_err, 0);
        check({tag, "_n_clear"}, n_clr, K);
        check({tag, "_first_clear_cycle"}, first_clr, 1);
        check({tag, "_n_valid_in"}, n_vin, K * K);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad;

        for (int i = 0; i < 32; i++) m_mem[i] = 8'd0;
        for (int i = 0; i < 8; i++) begin
            x_mem[i] = 8'd0;
            b_mem[i] = 8'd0;
        end
        load_identity();

        #1 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Identity matrix, L=1: writes at 8,16,24,32, done at 33.
        run_job("identity", 8, 1'b0, 1'b0);

        // All -128 operands: 4 * 16384 wraps to 0, plus bias -1.
        for (int i = 0; i < K * K; i++) m_mem[i] = 8'h80;
        for (int i = 0; i < K; i++) begin
            x_mem[i]   = 8'h80;
            b_mem[i]   = 8'hFF;
            exp_res[i] = 16'hFFFF;
        end
        run_job("wrap", 8, 1'b0, 1'b0);

        // Row r = [r+1,-1,2,0], x = [3,5,-7,9]: dot = 3r-16;
        // bias [0,1,-2,3] -> -16, -12, -12, -4.
        for (int r = 0; r < K; r++) begin
            m_mem[r*K+0] = 8'(r + 1);
            m_mem[r*K+1] = 8'hFF;
            m_mem[r*K+2] = 8'd2;
            m_mem[r*K+3] = 8'd0;
        end
        x_mem[0] = 8'd3;  x_mem[1] = 8'd5;  x_mem[2] = 8'hF9; x_mem[3] = 8'd9;
        b_mem[0] = 8'd0;  b_mem[1] = 8'd1;  b_mem[2] = 8'hFE; b_mem[3] = 8'd3;
        exp_res[0] = 16'hFFF0;
        exp_res[1] = 16'hFFF4;
        exp_res[2] = 16'hFFF4;
        exp_res[3] = 16'hFFFC;
        run_job("mixed", 8, 1'b0, 1'b0);

        // Start held high: no restart while busy; IDLE at 34, next CLR at 35.
        load_identity();
        run_job("held_first", 8, 1'b1, 1'b0);
        run_job("held_second", 8, 1'b0, 1'b0);

        // Reset in ISSUE of row 2 (row 2 CLR at 17, ISSUE 18..21, j=1 at 19).
        start = 1'b1;
        for (int rel = 1; rel <= 19; rel++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_pre_addr_m", 32'(addr_m), 32'd9);
        reset = 1'b1;
        #1 check_all_zero("rst_mid");
        n_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            if (res_wr_en || done || busy) n_bad++;
        end
        check("rst_mid_quiet", n_bad, 0);
        run_job("after_reset", 8, 1'b0, 1'b0);

        // L=3 with stray valid_out pulses in IDLE and WB: row time 10, done 41.
        mac_lat = 3;
        spur    = 1'b1;
        @(negedge clk);
        spur    = 1'b0;
        check("lat3_idle_after_spur", 32'(busy), 32'd0);
        run_job("lat3", 10, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
